// File: rtl/mdu_divider_pkg.sv
// Shared definitions for the multicycle divider and the ALU-side divide FSM.
// Holds the operand width, the fixed cycle count and the two-state encoding.
package mdu_divider_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CYCLES = 32;
    localparam int DIV_CNT_W  = 6;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

endpackage

// File: rtl/mdu_divider_step.sv
// One restoring-division iteration: shift {rem, quo} left, then trial-subtract
// the divisor magnitude and keep the result only when it does not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        trial   = shifted - {2'b00, divisor};
        rem_out = shifted[WIDTH:0];
        quo_out = {quo_in[WIDTH-2:0], 1'b0};
        // A clear top bit means the subtraction did not borrow.
        if (!trial[WIDTH+1]) begin
            rem_out    = trial[WIDTH:0];
            quo_out[0] = 1'b1;
        end
    end

endmodule

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider for MIPS32 div/divu: takes a start pulse, holds
// Stall for a fixed WIDTH cycles, then presents signed or unsigned Q/R.
module mdu_divider
    import mdu_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             OP_div,
    input  logic             OP_divu,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Stall
);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    // OP_div takes priority, so a simultaneous pair resolves to signed.
    assign is_signed    = OP_div;
    assign start        = (OP_div | OP_divu) && (state == DIV_IDLE);
    assign dividend_abs = (is_signed && Dividend[WIDTH-1]) ? -Dividend : Dividend;
    assign divisor_abs  = (is_signed && Divisor[WIDTH-1])  ? -Divisor  : Divisor;

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .divisor (divisor_mag),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the operand/partial-result registers are left unreset on
            // purpose; they are always loaded on the start edge before use.
            state     <= DIV_IDLE;
            Stall     <= 1'b0;
            count     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        neg_q       <= is_signed & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                        neg_r       <= is_signed & Dividend[WIDTH-1];
                        divisor_mag <= divisor_abs;
                        quo         <= dividend_abs;
                        rem         <= '0;
                        count       <= CNT_W'(WIDTH);
                        state       <= DIV_BUSY;
                        Stall       <= 1'b1;
                    end
                end
                DIV_BUSY: begin
                    rem   <= step_rem;
                    quo   <= step_quo;
                    count <= count - CNT_W'(1);
                    // Final iteration: publish the signed-corrected result now.
                    if (count == CNT_W'(1)) begin
                        Quotient  <= neg_q ? -step_quo : step_quo;
                        Remainder <= neg_r ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
                        state     <= DIV_IDLE;
                        Stall     <= 1'b0;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_divider.sv
// Self-checking bench for mdu_divider: a reference model pushes expected
// results at start time and a monitor pops them when Stall falls.
module tb_mdu_divider;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        OP_div = 1'b0;
    logic        OP_divu = 1'b0;
    logic [31:0] Dividend = '0;
    logic [31:0] Divisor = '0;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        Stall;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   busy_cyc = 0;

    mdu_divider dut (
        .clock     (clock),
        .reset     (reset),
        .OP_div    (OP_div),
        .OP_divu   (OP_divu),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Stall     (Stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa;
        int   sd;
        e.a = a;
        e.b = b;
        if (b == 32'd0) begin
            e.q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            e.r = a;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else begin
            sa  = a;
            sd  = b;
            e.q = sa / sd;
            e.r = sa % sd;
        end
        return e;
    endfunction

    // Caller is at a negedge with the DUT idle; the start edge is the next posedge.
    task automatic start_op(input bit s, input bit u, input logic [31:0] a, input logic [31:0] b);
        OP_div   = s;
        OP_divu  = u;
        Dividend = a;
        Divisor  = b;
        sb.push_back(model(s, a, b));
        @(negedge clock);
        OP_div   = 1'b0;
        OP_divu  = 1'b0;
        Dividend = $urandom;
        Divisor  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Stall && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (Stall) check("done_timeout", 32'(Stall), 32'd0);
    endtask

    // Monitor: counts Stall-high cycles and scores each completion.
    initial begin
        logic        rst_edge;
        logic        prev;
        logic [31:0] idv;
        exp_t        e;
        prev = 1'b0;
        forever begin
            @(posedge clock);
            rst_edge = reset;
            #1;
            if (rst_edge) begin
                busy_cyc = 0;
                prev     = Stall;
            end else begin
                if (Stall) busy_cyc++;
                if (prev && !Stall) begin
                    check("latency", 32'(busy_cyc), 32'd32);
                    busy_cyc = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("quotient", Quotient, e.q);
                        check("remainder", Remainder, e.r);
                        if (e.b != 32'd0) begin
                            idv = Quotient * e.b + Remainder;
                            check("identity", idv, e.a);
                        end
                    end
                end
                prev = Stall;
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bit          s;

        repeat (3) @(negedge clock);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_q", Quotient, 32'd0);
        check("rst_r", Remainder, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        start_op(0, 1, 32'd100, 32'd7);
        check("stall_high", 32'(Stall), 32'd1);
        wait_idle();
        repeat (5) @(negedge clock);
        check("hold_q", Quotient, 32'd14);
        check("hold_r", Remainder, 32'd2);

        start_op(1, 0, -32'sd7, 32'd2);       wait_idle();
        start_op(1, 0, 32'd7, -32'sd2);       wait_idle();
        start_op(1, 0, -32'sd7, -32'sd2);     wait_idle();
        start_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        start_op(0, 1, 32'hFFFF_FFFF, 32'd1); wait_idle();
        start_op(0, 1, 32'd5, 32'd0);         wait_idle();
        start_op(1, 0, -32'sd5, 32'd0);       wait_idle();
        start_op(1, 0, 32'd5, 32'd0);         wait_idle();

        // Both starts high: signed wins.
        start_op(1, 1, -32'sd7, 32'd2);
        wait_idle();

        // Start pulse while busy must be ignored.
        start_op(0, 1, 32'd100, 32'd7);
        repeat (5) @(negedge clock);
        OP_divu  = 1'b1;
        Dividend = 32'd55;
        Divisor  = 32'd3;
        @(negedge clock);
        OP_divu  = 1'b0;
        check("ignored_stall", 32'(Stall), 32'd1);
        wait_idle();

        // Back-to-back: start in the first Stall-low cycle.
        start_op(0, 1, 32'd1000, 32'd10);
        check("b2b_stall", 32'(Stall), 32'd1);
        wait_idle();

        // Reset at iteration 10 aborts.
        start_op(1, 0, -32'sd1234, 32'd5);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_stall", 32'(Stall), 32'd0);
        check("abort_q", Quotient, 32'd0);
        check("abort_r", Remainder, 32'd0);
        sb.delete();
        reset = 1'b0;
        @(negedge clock);
        start_op(0, 1, 32'd9, 32'd3);
        wait_idle();

        for (int i = 0; i < 1500; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = -32'($urandom_range(0, 15));
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            start_op(s, ~s, a, b);
            wait_idle();
        end

        repeat (3) @(negedge clock);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
